spike_aer_encoder: RTL and testbench
====================================

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter N_NEURONS, default 8: number of spike inputs from the LIF core array.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries (power of two).
REQ-003 SHALL have parameter TS_W, default 8: timestamp width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port spike_in  input  N_NEURONS  one-cycle spike pulses from the LIF core, bit i = neuron i.
REQ-007 SHALL have port step_tick  input  1  one-cycle time-step strobe; advances timestamp.
REQ-008 SHALL have port aer_valid  output  1  output event present.
REQ-009 SHALL have port aer_ready  input  1  consumer accepts event when aer_valid and aer_ready are both high.
REQ-010 SHALL have port aer_addr  output  clog2(N_NEURONS)  neuron index of head event.
REQ-011 SHALL have port aer_ts  output  TS_W  timestamp of head event.
REQ-012 SHALL have port drop_cnt  output  8  saturating count of merged (lost) spikes.
REQ-013 SHALL have port fifo_full  output  1  event FIFO full.

Function
REQ-014 SHALL keep a pending vector; each cycle pending <= (pending & ~grant) | spike_in.
REQ-015 SHALL select grant = lowest-index set pending bit (one-hot) in each cycle where pending is nonzero and the FIFO can accept.
REQ-016 SHALL treat the FIFO as able to accept when not full, or when full and a pop occurs in the same cycle.
REQ-017 SHALL, on grant, write {index, ts_cnt} into the FIFO; ts_cnt is the value in that cycle, before any step_tick increment.
REQ-018 SHALL, when the FIFO cannot accept, issue no grant and retain all pending bits (backpressure, no loss).
REQ-019 SHALL, when spike_in bit i is high and pending bit i is high and not granted, merge the spike and increment drop_cnt by one per merged bit, saturating at 255.
REQ-020 SHALL increment ts_cnt by 1 on step_tick, wrapping from 2^TS_W-1 to 0.
REQ-021 SHALL use a show-ahead FIFO: aer_valid = not empty; aer_addr and aer_ts show the head entry and stay stable while aer_valid and not aer_ready.
REQ-022 SHALL give a latency from spike_in high in cycle t to aer_valid in cycle t+2, when the FIFO is empty and there is no lower-index pending bit.
REQ-023 SHALL drain one event per cycle at most; with aer_ready held high, sustained throughput is 1 event/cycle.
REQ-024 SHALL hold fifo_full high exactly when the occupancy equals FIFO_DEPTH.

Reset
REQ-025 SHALL, on rst high at a clock edge, clear pending, FIFO pointers and occupancy, ts_cnt, and drop_cnt to 0.
REQ-026 SHALL give the following values from the first edge with rst high: aer_valid=0, aer_addr=0, aer_ts=0, drop_cnt=0, fifo_full=0.
REQ-027 SHALL, when reset is asserted mid-drain, discard all queued and pending events; spike_in in the reset cycle is ignored.

Structure
REQ-028 SHALL place N_NEURONS, FIFO_DEPTH, TS_W defaults and an aer_event typedef {addr, ts} in shared package lif_pkg.
REQ-029 SHALL implement the FIFO as a sub-module aer_fifo (synchronous, show-ahead, push/pop/full/empty).
REQ-030 SHALL implement the priority select and pending logic inline in spike_aer_encoder.

Verification
REQ-031 SHALL cover a single spike: ts_cnt=5, spike_in=0x04 at cycle t, aer_ready=1 -> aer_valid at t+2 with addr=2, ts=5, for one cycle.
REQ-032 SHALL cover a burst: spike_in=0xFF in one cycle, aer_ready=1 -> 8 consecutive events with addr 0..7, no drops, drop_cnt=0.
REQ-033 SHALL cover backpressure: aer_ready=0, spike_in=0xFF then 0x01 two cycles later -> FIFO fills (fifo_full=1), 0 remains pending; aer_ready=1 -> order 0..7 then 0, no loss.
REQ-034 SHALL cover a merge: aer_ready=0, FIFO full, neuron 3 pending, spike_in=0x08 three times -> drop_cnt=3; 300 merges -> drop_cnt=255.
REQ-035 SHALL cover timestamp wrap: 255 step_ticks then 1 more -> ts_cnt 255 then 0; spikes stamped 255 and 0 respectively.
REQ-036 SHALL cover reset mid-drain: 5 events queued, rst for 1 cycle -> aer_valid=0 next cycle, drop_cnt=0, no stale events after release.

Source files
------------

// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lif_pkg
//  Description : Shared defaults and types for the LIF core / AER output path.
//                DEF_* constants give the default array size, event FIFO
//                depth and timestamp width; aer_event_t is the {addr, ts}
//                event word for the default configuration.
//  Revision    : 1.0  initial release
// ============================================================================
package lif_pkg;

    localparam int DEF_N_NEURONS  = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_TS_W       = 8;
    localparam int DEF_ADDR_W     = $clog2(DEF_N_NEURONS);

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_TS_W-1:0]   ts;
    } aer_event_t;

    // Address width for n neurons; a single neuron still needs one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : lif_pkg
`default_nettype wire

// File: rtl/aer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : aer_fifo
//  Description : Synchronous show-ahead FIFO for AER events. The head entry
//                is visible on o_data whenever o_empty is low; o_data reads
//                zero while empty so nothing stale leaks out after reset.
//                A push while full is accepted only if a pop happens in the
//                same cycle (the freed slot is reused).
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_push/i_data - write request and event word
//                i_pop         - remove head entry (ignored when empty)
//                o_data        - head entry
//                o_full/o_empty- occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module aer_fifo #(
    parameter int DEPTH  = 8,   // power of two, >= 2
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: every read is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule : aer_fifo
`default_nettype wire

// File: rtl/spike_aer_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : spike_aer_encoder
//  Description : Converts parallel one-cycle spike pulses into a serial
//                address-event stream. Spikes are latched into a pending
//                vector; each cycle the lowest-index pending neuron is
//                granted and written to the event FIFO as {index, ts_cnt}.
//                A spike arriving on a neuron that is still pending is merged
//                and counted in drop_cnt (saturating at 255).
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                spike_in  - spike pulses, bit i = neuron i
//                step_tick - advances the timestamp counter
//                aer_valid / aer_ready / aer_addr / aer_ts - event output
//                drop_cnt  - merged spike count
//                fifo_full - event FIFO is full
//  Revision    : 1.0  initial release
// ============================================================================
module spike_aer_encoder
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TS_W       = DEF_TS_W,
    localparam int ADDR_W    = addr_width(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 step_tick,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [ADDR_W-1:0]    aer_addr,
    output logic [TS_W-1:0]      aer_ts,
    output logic [7:0]           drop_cnt,
    output logic                 fifo_full
);

    localparam int CNT_W  = $clog2(N_NEURONS + 1);
    localparam int SUM_W  = CNT_W + 9;
    localparam int DATA_W = ADDR_W + TS_W;

    logic [N_NEURONS-1:0] r_pending;
    logic [TS_W-1:0]      r_ts_cnt;
    logic [7:0]           r_drop_cnt;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic                 w_can_accept;
    logic [N_NEURONS-1:0] w_grant;
    logic [ADDR_W-1:0]    w_grant_idx;
    logic                 w_grant_vld;
    logic [N_NEURONS-1:0] w_merge;
    logic [CNT_W-1:0]     w_drop_n;
    logic [SUM_W-1:0]     w_drop_sum;
    logic [DATA_W-1:0]    w_fifo_rdata;

    assign w_pop        = !w_fifo_empty && aer_ready;
    // A full FIFO can still take the grant when the head leaves this cycle.
    assign w_can_accept = !w_fifo_full || w_pop;

    // Lowest-index priority select: scan downward so the lowest set bit wins.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_vld = 1'b0;
        if (w_can_accept) begin
            for (int i = N_NEURONS - 1; i >= 0; i--) begin
                if (r_pending[i]) begin
                    w_grant     = '0;
                    w_grant[i]  = 1'b1;
                    w_grant_idx = ADDR_W'(i);
                    w_grant_vld = 1'b1;
                end
            end
        end
    end

    // A fresh spike on a neuron that stays pending is folded into the
    // existing request; count each such lost spike.
    assign w_merge = spike_in & r_pending & ~w_grant;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < N_NEURONS; i++)
            w_drop_n = w_drop_n + CNT_W'(w_merge[i]);
    end

    assign w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_ts_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_grant) | spike_in;
            if (step_tick)
                r_ts_cnt <= r_ts_cnt + 1'b1;
            r_drop_cnt <= (w_drop_sum > SUM_W'(255)) ? 8'hFF : w_drop_sum[7:0];
        end
    end

    aer_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant_vld),
        .i_data  ({w_grant_idx, r_ts_cnt}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign aer_valid = !w_fifo_empty;
    assign aer_addr  = w_fifo_rdata[DATA_W-1:TS_W];
    assign aer_ts    = w_fifo_rdata[TS_W-1:0];
    assign drop_cnt  = r_drop_cnt;
    assign fifo_full = w_fifo_full;

endmodule : spike_aer_encoder
`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_aer_encoder
//  Description : Directed self-checking bench for spike_aer_encoder with the
//                default configuration (8 neurons, 8-deep FIFO, 8-bit ts).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spike_aer_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] spike_in;
    logic       step_tick;
    logic       aer_valid;
    logic       aer_ready;
    logic [2:0] aer_addr;
    logic [7:0] aer_ts;
    logic [7:0] drop_cnt;
    logic       fifo_full;

    int n_checks = 0;
    int n_errors = 0;

    spike_aer_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .spike_in  (spike_in),
        .step_tick (step_tick),
        .aer_valid (aer_valid),
        .aer_ready (aer_ready),
        .aer_addr  (aer_addr),
        .aer_ts    (aer_ts),
        .drop_cnt  (drop_cnt),
        .fifo_full (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        spike_in  = '0;
        step_tick = 1'b0;
        aer_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        chk("rst_valid", aer_valid, 0);
        chk("rst_addr",  aer_addr,  0);
        chk("rst_ts",    aer_ts,    0);
        chk("rst_drop",  drop_cnt,  0);
        chk("rst_full",  fifo_full, 0);
        rst = 1'b0;

        // ---------------- single spike, ts=5 ----------------
        step_tick = 1'b1;
        repeat (5) step();
        step_tick = 1'b0;
        aer_ready = 1'b1;
        spike_in  = 8'h04;
        step();
        spike_in  = 8'h00;
        chk("single_t1_valid", aer_valid, 0);
        step();
        chk("single_t2_valid", aer_valid, 1);
        chk("single_addr",     aer_addr,  2);
        chk("single_ts",       aer_ts,    5);
        step();
        chk("single_t3_valid", aer_valid, 0);

        // ---------------- burst 0xFF ----------------
        spike_in = 8'hFF;
        step();
        spike_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("burst_valid%0d", i), aer_valid, 1);
            chk($sformatf("burst_addr%0d", i),  aer_addr,  i);
        end
        step();
        chk("burst_end_valid", aer_valid, 0);
        chk("burst_drop",      drop_cnt,  0);

        // ---------------- backpressure ----------------
        aer_ready = 1'b0;
        spike_in  = 8'hFF;
        step();
        spike_in  = 8'h00;
        repeat (7) step();
        chk("bp_not_full_yet", fifo_full, 0);
        step();
        chk("bp_full", fifo_full, 1);
        // Neuron 0 spikes again once the FIFO is full, so it has to wait
        // behind the whole burst.
        spike_in = 8'h01;
        step();
        spike_in = 8'h00;
        step();
        chk("bp_still_full", fifo_full, 1);
        chk("bp_head_stable", aer_addr, 0);
        aer_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_drain_addr%0d", i), aer_addr, i);
            step();
        end
        chk("bp_tail_valid", aer_valid, 1);
        chk("bp_tail_addr",  aer_addr,  0);
        step();
        chk("bp_empty", aer_valid, 0);
        chk("bp_drop",  drop_cnt,  0);

        // ---------------- merge / saturation ----------------
        do_reset();
        aer_ready = 1'b0;
        spike_in  = 8'hFF;
        step();
        spike_in  = 8'h00;
        repeat (8) step();
        chk("merge_full", fifo_full, 1);
        spike_in = 8'h08;
        step();                         // neuron 3 becomes pending
        chk("merge_drop0", drop_cnt, 0);
        repeat (3) step();
        chk("merge_drop3", drop_cnt, 3);
        repeat (251) step();
        chk("merge_drop254", drop_cnt, 254);
        repeat (46) step();             // 300 merges in total
        chk("merge_drop_sat", drop_cnt, 255);
        spike_in = 8'h00;

        // ---------------- timestamp wrap ----------------
        do_reset();
        aer_ready = 1'b1;
        step_tick = 1'b1;
        repeat (255) step();
        step_tick = 1'b0;
        spike_in  = 8'h01;
        step();
        spike_in  = 8'h00;
        step();
        chk("wrap_ts255_addr", aer_addr, 0);
        chk("wrap_ts255",      aer_ts,   255);
        step_tick = 1'b1;
        step();
        step_tick = 1'b0;
        spike_in  = 8'h02;
        step();
        spike_in  = 8'h00;
        // Grant cycle coincides with a tick: stamp is the pre-increment value.
        step_tick = 1'b1;
        step();
        step_tick = 1'b0;
        chk("wrap_ts0_addr", aer_addr, 1);
        chk("wrap_ts0",      aer_ts,   0);
        spike_in = 8'h10;
        step();
        spike_in = 8'h00;
        step();
        chk("wrap_ts1_addr", aer_addr, 4);
        chk("wrap_ts1",      aer_ts,   1);
        step();

        // ---------------- reset mid-drain ----------------
        aer_ready = 1'b0;
        spike_in  = 8'h1F;
        step();
        spike_in  = 8'h00;
        repeat (5) step();
        chk("mid_queued_valid", aer_valid, 1);
        spike_in = 8'hE0;               // still pending at reset
        step();
        rst      = 1'b1;
        spike_in = 8'hFF;               // ignored in the reset cycle
        step();
        rst      = 1'b0;
        spike_in = 8'h00;
        chk("mid_rst_valid", aer_valid, 0);
        chk("mid_rst_drop",  drop_cnt,  0);
        chk("mid_rst_full",  fifo_full, 0);
        chk("mid_rst_addr",  aer_addr,  0);
        chk("mid_rst_ts",    aer_ts,    0);
        aer_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mid_no_stale%0d", i), aer_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_spike_aer_encoder
`default_nettype wire
